// File: rtl/linebuf_pkg.sv
// -----------------------------------------------------------------------------
// linebuf_pkg
// Shared definitions for the line-buffer writer: geometry of one scanline
// (128 words of 16 eight-bit pixels), the span request record, the span FSM
// state encoding and the clipped span-end helper.
// -----------------------------------------------------------------------------
package linebuf_pkg;

   localparam int LB_WORDS        = 128;
   localparam int LB_PIX_PER_WORD = 16;
   localparam int LB_ADDR_W       = 11;   // pixel address width
   localparam int LB_WORD_W       = 7;    // word address width
   localparam int LB_WE_W         = 16;   // one write enable per pixel
   localparam int LB_DATA_W       = 128;  // 16 pixels x 8 bits

   typedef struct packed {
      logic [LB_ADDR_W-1:0] x;
      logic [LB_ADDR_W-1:0] len;
      logic [7:0]           colour;
   } span_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SPAN = 1'b1
   } span_state_t;

   // Last pixel covered by a span, saturated at the end of the line.
   // Only meaningful for len > 0.
   function automatic logic [LB_ADDR_W-1:0] span_end(input logic [LB_ADDR_W-1:0] x,
                                                     input logic [LB_ADDR_W-1:0] len);
      logic [LB_ADDR_W:0] sum;
      sum = {1'b0, x} + {1'b0, len} - 12'd1;
      return sum[LB_ADDR_W] ? '1 : sum[LB_ADDR_W-1:0];
   endfunction

endpackage

// File: rtl/linebuffer_writer_if.sv
// -----------------------------------------------------------------------------
// linebuffer_writer_if
// Request side of the line-buffer writer: span fill requests and buffer flip
// requests.
//   span_valid/span_ready : span request handshake; span_x, span_len,
//                           span_colour are the payload.
//   flip_req/flip_ready   : buffer swap handshake (no payload).
// Handshake rule (both channels): a transfer happens on a rising clk_draw edge
// where valid (or flip_req) and ready are both 1. The master holds the payload
// stable while valid is high; ready may depend combinationally on the
// requests, never the other way round.
// Modports: master = requester, slave = linebuffer_writer.
// -----------------------------------------------------------------------------
interface linebuffer_writer_if;
   import linebuf_pkg::*;

   logic                 span_valid;
   logic                 span_ready;
   logic [LB_ADDR_W-1:0] span_x;
   logic [LB_ADDR_W-1:0] span_len;
   logic [7:0]           span_colour;
   logic                 flip_req;
   logic                 flip_ready;

   modport master (
      output span_valid, span_x, span_len, span_colour, flip_req,
      input  span_ready, flip_ready
   );

   modport slave (
      input  span_valid, span_x, span_len, span_colour, flip_req,
      output span_ready, flip_ready
   );

endinterface

// File: rtl/span_mask.sv
// -----------------------------------------------------------------------------
// span_mask
// Combinational per-pixel write-enable mask for one word of a span.
//   word      : word index being written
//   start_pix : first pixel of the span
//   end_pix   : last pixel of the span (already clipped)
//   mask      : bit 15-p enables pixel p of the word
// -----------------------------------------------------------------------------
module span_mask
   import linebuf_pkg::*;
(
   input  logic [LB_WORD_W-1:0] word,
   input  logic [LB_ADDR_W-1:0] start_pix,
   input  logic [LB_ADDR_W-1:0] end_pix,
   output logic [LB_WE_W-1:0]   mask
);

   always_comb begin
      mask = '0;
      for (int p = 0; p < LB_PIX_PER_WORD; p++) begin
         mask[LB_PIX_PER_WORD-1-p] = ({word, 4'(p)} >= start_pix) &&
                                     ({word, 4'(p)} <= end_pix);
      end
   end

endmodule

// File: rtl/linebuffer_writer.sv
// -----------------------------------------------------------------------------
// linebuffer_writer
// Draw-domain writer for a double-buffered scanline. A span engine fills runs
// of pixels in the off-screen buffer one word per cycle; after a flip, a clear
// sweep wipes the new off-screen buffer (the one just scanned out) word by
// word, staying behind the pixel-side scanout pointer.
// Ports:
//   clk_draw, rst_draw : clock, synchronous active-high reset
//   req                : span / flip request interface (slave)
//   scan_word          : scanout word index, synchronised, non-decreasing per line
//   buffsel_draw       : buffer select
//   addr/we/colour_off_draw : off-screen write port (span fills)
//   addr/we/colour_on_draw  : on-screen clear port (clear sweep)
//   busy               : span engine or clear sweep active
//   state_dbg          : span FSM state
// -----------------------------------------------------------------------------
module linebuffer_writer
   import linebuf_pkg::*;
#(
   parameter logic [7:0] CLEAR_COLOUR = 8'h00
) (
   input  logic                 clk_draw,
   input  logic                 rst_draw,
   linebuffer_writer_if.slave   req,
   input  logic [LB_WORD_W-1:0] scan_word,
   output logic                 buffsel_draw,
   output logic [LB_WORD_W-1:0] addr_off_draw,
   output logic [LB_WE_W-1:0]   we_off_draw,
   output logic [LB_DATA_W-1:0] colour_off_draw,
   output logic [LB_WORD_W-1:0] addr_on_draw,
   output logic                 we_on_draw,
   output logic [LB_DATA_W-1:0] colour_on_draw,
   output logic                 busy,
   output span_state_t          state_dbg
);

   span_state_t          state, state_next;
   logic [LB_ADDR_W-1:0] start_q, end_q;
   logic [LB_WORD_W-1:0] cur_word, last_word;
   logic                 sweep_active, sweep_next;
   logic [LB_WORD_W-1:0] clear_ptr, scan_prev;

   span_t                req_span;
   logic [LB_ADDR_W-1:0] req_end;
   logic                 span_accept, span_go, flip_accept;
   logic                 span_last, clear_last, clear_fire;
   logic [LB_WORD_W-1:0] mask_word;
   logic [LB_ADDR_W-1:0] mask_start, mask_end;
   logic [LB_WE_W-1:0]   mask;

   assign req_span  = '{x: req.span_x, len: req.span_len, colour: req.span_colour};
   assign req_end   = span_end(req_span.x, req_span.len);
   assign state_dbg = state;

   // Span wins over flip: span_ready only drops for a flip that will really be
   // taken this cycle (no span pending and the previous sweep finished).
   assign req.span_ready = !rst_draw && (state == ST_IDLE) &&
                           !(req.flip_req && !req.span_valid && !sweep_active);
   assign req.flip_ready = !rst_draw && (state == ST_IDLE) &&
                           !req.span_valid && !sweep_active;

   assign span_accept = req.span_valid && req.span_ready;
   assign span_go     = span_accept && (req_span.len != '0);
   assign flip_accept = req.flip_req && req.flip_ready;
   assign span_last   = (cur_word == last_word);
   assign clear_last  = (clear_ptr == LB_WORD_W'(LB_WORDS-1));

   // A word may be cleared only once scanout has moved past it. The last word
   // is never strictly behind scanout, so it waits for the end-of-line wrap.
   assign clear_fire = sweep_active &&
                       (clear_last ? (scan_word < scan_prev) : (scan_word > clear_ptr));

   always_comb begin
      state_next = state;
      if (state == ST_IDLE) begin
         if (span_go) state_next = ST_SPAN;
      end else begin
         if (span_last) state_next = ST_IDLE;
      end

      sweep_next = sweep_active;
      if (flip_accept)                    sweep_next = 1'b1;
      else if (clear_fire && clear_last)  sweep_next = 1'b0;

      // Mask source: the first word comes straight from the request, later
      // words from the latched span bounds.
      if (state == ST_SPAN) begin
         mask_word  = cur_word + LB_WORD_W'(1);
         mask_start = start_q;
         mask_end   = end_q;
      end else begin
         mask_word  = req_span.x[LB_ADDR_W-1:4];
         mask_start = req_span.x;
         mask_end   = req_end;
      end
   end

   span_mask u_span_mask (
      .word      (mask_word),
      .start_pix (mask_start),
      .end_pix   (mask_end),
      .mask      (mask)
   );

   always_ff @(posedge clk_draw) begin
      if (rst_draw) begin
         state           <= ST_IDLE;
         start_q         <= '0;
         end_q           <= '0;
         cur_word        <= '0;
         last_word       <= '0;
         sweep_active    <= 1'b0;
         clear_ptr       <= '0;
         scan_prev       <= '0;
         buffsel_draw    <= 1'b0;
         addr_off_draw   <= '0;
         we_off_draw     <= '0;
         colour_off_draw <= '0;
         addr_on_draw    <= '0;
         we_on_draw      <= 1'b0;
         colour_on_draw  <= '0;
         busy            <= 1'b0;
      end else begin
         state        <= state_next;
         sweep_active <= sweep_next;
         busy         <= (state_next != ST_IDLE) || sweep_next;
         scan_prev    <= scan_word;
         we_off_draw  <= '0;
         we_on_draw   <= 1'b0;

         // Span engine: outputs are registered, so the first word is issued
         // on the accepting edge and each SPAN cycle shows one write.
         if (state == ST_IDLE) begin
            if (span_go) begin
               start_q         <= req_span.x;
               end_q           <= req_end;
               cur_word        <= req_span.x[LB_ADDR_W-1:4];
               last_word       <= req_end[LB_ADDR_W-1:4];
               addr_off_draw   <= req_span.x[LB_ADDR_W-1:4];
               we_off_draw     <= mask;
               colour_off_draw <= {LB_PIX_PER_WORD{req_span.colour}};
            end
         end else if (!span_last) begin
            cur_word      <= mask_word;
            addr_off_draw <= mask_word;
            we_off_draw   <= mask;
         end

         // Flip and clear sweep.
         if (flip_accept) begin
            buffsel_draw <= ~buffsel_draw;
            clear_ptr    <= '0;
         end else if (clear_fire) begin
            addr_on_draw   <= clear_ptr;
            we_on_draw     <= 1'b1;
            colour_on_draw <= {LB_PIX_PER_WORD{CLEAR_COLOUR}};
            clear_ptr      <= clear_ptr + LB_WORD_W'(1);
         end
      end
   end

endmodule
